warmup2_mpsubtractor: RTL

Multi-precision subtractor for 514-bit operands. It computes A − B over 128-bit limbs, one limb per cycle, and returns a 515-bit two's-complement result with a start/done handshake. It is the subtraction counterpart to the multi-precision adder and uses the same operand widths and handshake. It is the datapath step the modular-reduction logic will use when it subtracts the modulus after an addition.

---
 rtl/warmup2_mpsubtractor_pkg.sv | 16 +
 rtl/warmup2_mpsubtractor_if.sv | 31 +++
 rtl/warmup2_mpsubtractor_limb_sub.sv | 20 ++
 rtl/warmup2_mpsubtractor.sv | 107 ++++++++++
 4 files changed

// File: rtl/warmup2_mpsubtractor_pkg.sv
// Shared constants and state encoding for the multi-precision datapath blocks.
// Operand geometry is 514-bit values handled as five 128-bit limbs.
package mp_pkg;

    localparam int MP_N     = 514;
    localparam int MP_W     = 128;
    localparam int MP_K     = (MP_N + MP_W - 1) / MP_W;
    localparam int MP_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } mp_state_e;

endpackage

// File: rtl/warmup2_mpsubtractor_if.sv
// Start/done operand bus between a requester (master) and the subtractor (slave).
// The requester drives the start pulse and operands; the subtractor returns the result.
interface warmup2_mpsubtractor_if
    import mp_pkg::*;
#(
    parameter int N = MP_N
);

    logic         instart;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic [N:0]   outC;
    logic         outdone;

    modport master (
        output instart,
        output inA,
        output inB,
        input  outC,
        input  outdone
    );

    modport slave (
        input  instart,
        input  inA,
        input  inB,
        output outC,
        output outdone
    );

endinterface

// File: rtl/warmup2_mpsubtractor_limb_sub.sv
// One limb of the ripple subtractor: W-bit difference with borrow-in/borrow-out.
// Purely combinational; the caller holds all the state between limbs.
module mp_limb_sub #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] diff;

    // The extra top bit wraps to 1 exactly when a < b + bin, which is the borrow out.
    assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign d    = diff[W-1:0];
    assign bout = diff[W];

endmodule

// File: rtl/warmup2_mpsubtractor.sv
// Multi-precision subtractor: A - B over W-bit limbs, one limb per cycle, least
// significant first, with a registered {borrow, difference} result and a done pulse.
module warmup2_mpsubtractor
    import mp_pkg::*;
#(
    parameter int N = MP_N,
    parameter int W = MP_W
) (
    input  logic                   clk,
    input  logic                   reset,
    warmup2_mpsubtractor_if.slave  bus
);

    localparam int K  = (N + W - 1) / W;
    localparam int KW = K * W;
    localparam logic [MP_CNT_W-1:0] LAST_LIMB = MP_CNT_W'(K - 1);

    mp_state_e             state_q, state_d;
    logic [KW-1:0]         a_sh_q, a_sh_d;
    logic [KW-1:0]         b_sh_q, b_sh_d;
    logic [KW-1:0]         d_sh_q, d_sh_d;
    logic                  borrow_q, borrow_d;
    logic [MP_CNT_W-1:0]   cnt_q, cnt_d;
    logic [N:0]            out_c_q, out_c_d;
    logic                  out_done_q, out_done_d;

    logic [W-1:0]          limb_d;
    logic                  limb_bo;

    mp_limb_sub #(.W(W)) u_limb_sub (
        .a    (a_sh_q[W-1:0]),
        .b    (b_sh_q[W-1:0]),
        .bin  (borrow_q),
        .d    (limb_d),
        .bout (limb_bo)
    );

    // The result register is loaded from the difference as it will stand after the
    // last limb, so the value and the done pulse appear together on the edge into DONE.
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        d_sh_d     = d_sh_q;
        borrow_d   = borrow_q;
        cnt_d      = cnt_q;
        out_c_d    = out_c_q;
        out_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.instart) begin
                    a_sh_d   = {{(KW - N){1'b0}}, bus.inA};
                    b_sh_d   = {{(KW - N){1'b0}}, bus.inB};
                    d_sh_d   = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = {{W{1'b0}}, a_sh_q[KW-1:W]};
                b_sh_d   = {{W{1'b0}}, b_sh_q[KW-1:W]};
                d_sh_d   = {limb_d, d_sh_q[KW-1:W]};
                borrow_d = limb_bo;
                cnt_d    = cnt_q + MP_CNT_W'(1);
                if (cnt_q == LAST_LIMB) begin
                    out_c_d    = d_sh_d[N:0];
                    out_done_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            d_sh_q     <= '0;
            borrow_q   <= 1'b0;
            cnt_q      <= '0;
            out_c_q    <= '0;
            out_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            d_sh_q     <= d_sh_d;
            borrow_q   <= borrow_d;
            cnt_q      <= cnt_d;
            out_c_q    <= out_c_d;
            out_done_q <= out_done_d;
        end
    end

    assign bus.outC    = out_c_q;
    assign bus.outdone = out_done_q;

endmodule
